// File: rtl/prio_encoder_8to3_sync.sv
// Registered 8-to-3 priority encoder with input synchronizer, optional debounce and valid/ready output.
// Debounce (SETTLE state + stability counter) is built only when PRIO_ENC_DEBOUNCE_EN is defined.
module prio_encoder_8to3_sync #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EI_n,
   input  logic [7:0] I_n,
   output logic [2:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       GS_n,
   output logic       EO_n
);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || CNT_W < 1 ||
       ((STABLE_CYCLES - 1) >> CNT_W) != 0) begin : g_cfg_err
      $error("prio_encoder_8to3_sync: STABLE_CYCLES out of range or CNT_W too narrow");
   end

`ifdef PRIO_ENC_DEBOUNCE_EN
   typedef enum logic [1:0] {IDLE, SETTLE, HOLD, RELEASE} state_t;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   logic [CNT_W-1:0] cnt;
   logic [2:0]       cand;
`else
   typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
`endif

   state_t     state;
   logic [7:0] s1, s2;
   logic       any, en_any;
   logic [2:0] idx;

   // Ascending scan so the highest low bit wins.
   always_comb begin
      any = ~&s2;
      idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (!s2[i]) idx = 3'(i);
   end

   assign en_any = ~EI_n & any;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         s1    <= 8'hFF;
         s2    <= 8'hFF;
         code  <= 3'd0;
         valid <= 1'b0;
         GS_n  <= 1'b1;
         EO_n  <= 1'b1;
`ifdef PRIO_ENC_DEBOUNCE_EN
         cnt   <= '0;
         cand  <= 3'd0;
`endif
      end else begin
         s1   <= I_n;
         s2   <= s1;
         GS_n <= ~(~EI_n & any);
         EO_n <= ~(~EI_n & ~any);
         case (state)
            IDLE: begin
               if (en_any) begin
`ifdef PRIO_ENC_DEBOUNCE_EN
                  state <= SETTLE;
                  cand  <= idx;
                  cnt   <= '0;
`else
                  state <= HOLD;
                  code  <= idx;
                  valid <= 1'b1;
`endif
               end
            end
`ifdef PRIO_ENC_DEBOUNCE_EN
            SETTLE: begin
               // A change of winner takes priority over counter expiry.
               if (!en_any) begin
                  state <= IDLE;
               end else if (idx != cand) begin
                  cand <= idx;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HOLD;
                  code  <= cand;
                  valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            HOLD: begin
               if (ready) begin
                  valid <= 1'b0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               // Wait for the press to go away so it is reported only once.
               if (!en_any) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_encoder_8to3_sync.sv
// Self-checking bench for prio_encoder_8to3_sync against a streak-based reference model.
// Adapts expected latency to whether PRIO_ENC_DEBOUNCE_EN is defined.
module tb_prio_encoder_8to3_sync;
   localparam int S = 4;
`ifdef PRIO_ENC_DEBOUNCE_EN
   localparam int NEED = S + 1;   // consecutive enabled edges with the same winner
`else
   localparam int NEED = 1;
`endif
   localparam int LAT = NEED + 2; // edges from I_n change to valid

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       EI_n = 1'b0;
   logic [7:0] I_n = 8'h00;
   logic       ready = 1'b0;
   logic [2:0] code;
   logic       valid, GS_n, EO_n;

   int nchk = 0;
   int nfail = 0;

   prio_encoder_8to3_sync #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .EI_n(EI_n), .I_n(I_n),
      .code(code), .valid(valid), .ready(ready), .GS_n(GS_n), .EO_n(EO_n)
   );

   always #5 clk = ~clk;

   // Reference model: inputs pass a 2-deep delay line; a capture fires once the
   // same winner has been seen enabled for NEED edges in a row while armed.
   logic [7:0] ms1, ms2;
   logic       mgs, meo, mvalid;
   logic [2:0] mcode;
   bit         armed;
   int         streak, lastidx;

   always @(posedge clk) begin
      automatic int  w = -1;
      automatic bit  act;
      automatic int  ns;
      for (int i = 7; i >= 0; i--)
         if (ms2[i] == 1'b0 && w < 0) w = i;
      act = (EI_n == 1'b0) && (w >= 0);
      if (!rst_n) begin
         ms1 <= 8'hFF; ms2 <= 8'hFF; mgs <= 1'b1; meo <= 1'b1;
         mvalid <= 1'b0; mcode <= 3'd0; armed <= 1'b1; streak <= 0; lastidx <= 0;
      end else begin
         ms1 <= I_n;
         ms2 <= ms1;
         mgs <= !act;
         meo <= !((EI_n == 1'b0) && (w < 0));
         if (mvalid) begin
            if (ready) begin mvalid <= 1'b0; armed <= 1'b0; end
         end else if (!armed) begin
            if (!act) armed <= 1'b1;
         end else if (act) begin
            ns = (streak > 0 && w == lastidx) ? streak + 1 : 1;
            if (ns == NEED) begin
               mvalid <= 1'b1; mcode <= 3'(w); streak <= 0;
            end else begin
               streak <= ns; lastidx <= w;
            end
         end else begin
            streak <= 0;
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; I_n = 8'h00; EI_n = 1'b0; ready = 1'b0;
      repeat (2) @(negedge clk);
      nchk++;
      if ({code, valid, GS_n, EO_n} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
         nfail++; $display("FAIL reset_values: got %b want %b", {code, valid, GS_n, EO_n}, 6'b000011);
      end
      rst_n = 1'b1; I_n = 8'hFF;
      @(negedge clk);
      nchk++;
      if ({valid, EO_n, GS_n} !== 3'b001) begin
         nfail++; $display("FAIL reset_release: got valid/EO_n/GS_n %b want 001", {valid, EO_n, GS_n});
      end
      repeat (3) begin
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL reset_model: got %b want %b t=%0t", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, $time);
         end
      end
   endtask

   task automatic cleanup();
      ready = 1'b1; I_n = 8'hFF; EI_n = 1'b0;
      repeat (4) @(negedge clk);
      ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_priority();
      EI_n = 1'b0; ready = 1'b0; I_n = 8'b1101_0111;
      for (int e = 1; e <= LAT + 3; e++) begin
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL prio_model: got %b want %b edge %0d", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, e);
         end
         if (e == 3) begin
            nchk++;
            if (GS_n !== 1'b0) begin nfail++; $display("FAIL prio_gs_edge3: got %b want 0", GS_n); end
         end
         if (e == LAT - 1) begin
            nchk++;
            if (valid !== 1'b0) begin nfail++; $display("FAIL prio_early: got valid %b want 0", valid); end
         end
         if (e >= LAT) begin
            nchk++;
            if ({valid, code} !== {1'b1, 3'd5}) begin
               nfail++; $display("FAIL prio_capture: got valid/code %b/%0d want 1/5 edge %0d", valid, code, e);
            end
         end
      end
      ready = 1'b1;
      @(negedge clk); ready = 1'b0; nchk++;
      if (valid !== 1'b0) begin nfail++; $display("FAIL prio_accept: got valid %b want 0", valid); end
   endtask

   task automatic test_single_report();
      repeat (20) begin
         @(negedge clk); nchk++;
         if ({valid, code} !== {1'b0, 3'd5}) begin
            nfail++; $display("FAIL single_hold: got valid/code %b/%0d want 0/5", valid, code);
         end
      end
      I_n = 8'hFF;
      repeat (4) @(negedge clk);
      I_n = 8'b1111_1110;
      repeat (LAT + 2) begin
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL single_model: got %b want %b t=%0t", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, $time);
         end
      end
      nchk++;
      if ({valid, code} !== {1'b1, 3'd0}) begin
         nfail++; $display("FAIL single_new: got valid/code %b/%0d want 1/0", valid, code);
      end
      cleanup();
   endtask

   task automatic test_bounce();
      for (int c = 0; c < 20; c++) begin
         I_n = ((c / 2) % 2 == 0) ? 8'b1011_1111 : 8'b1111_0111;
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL bounce_model: got %b want %b cyc %0d", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, c);
         end
`ifdef PRIO_ENC_DEBOUNCE_EN
         nchk++;
         if (valid !== 1'b0) begin nfail++; $display("FAIL bounce_reject: got valid %b want 0 cyc %0d", valid, c); end
`endif
      end
      I_n = 8'b1011_1111;
      for (int e = 1; e <= LAT; e++) begin
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL bounce_settle_model: got %b want %b edge %0d", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, e);
         end
      end
`ifdef PRIO_ENC_DEBOUNCE_EN
      nchk++;
      if ({valid, code} !== {1'b1, 3'd6}) begin
         nfail++; $display("FAIL bounce_settle: got valid/code %b/%0d want 1/6", valid, code);
      end
`endif
      cleanup();
   endtask

   task automatic test_enable();
      EI_n = 1'b1; I_n = 8'h00;
      repeat (LAT + 3) @(negedge clk);
      nchk++;
      if ({valid, GS_n, EO_n} !== 3'b011) begin
         nfail++; $display("FAIL enable_gate: got valid/GS_n/EO_n %b want 011", {valid, GS_n, EO_n});
      end
      EI_n = 1'b0;
      repeat (NEED + 1) begin
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL enable_model: got %b want %b t=%0t", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, $time);
         end
      end
      nchk++;
      if ({valid, code} !== {1'b1, 3'd7}) begin
         nfail++; $display("FAIL enable_capture: got valid/code %b/%0d want 1/7", valid, code);
      end
      cleanup();
   endtask

   task automatic test_expiry_change();
      I_n = 8'b1110_1111;
      for (int e = 1; e <= LAT + S + 2; e++) begin
         if (e == 5) I_n = 8'b1100_1111;   // bit 5 wins at the would-be expiry edge
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL expiry_model: got %b want %b edge %0d", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, e);
         end
`ifdef PRIO_ENC_DEBOUNCE_EN
         if (e == LAT || e == LAT + S - 1) begin
            nchk++;
            if (valid !== 1'b0) begin nfail++; $display("FAIL expiry_restart: got valid %b want 0 edge %0d", valid, e); end
         end
         if (e == LAT + S) begin
            nchk++;
            if ({valid, code} !== {1'b1, 3'd5}) begin
               nfail++; $display("FAIL expiry_capture: got valid/code %b/%0d want 1/5", valid, code);
            end
         end
`endif
      end
      // ready on the same edge that enters HOLD must not cut valid short
      cleanup();
      I_n = 8'b1111_1101; ready = 1'b1;
      for (int e = 1; e <= LAT + 1; e++) begin
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL entry_ready_model: got %b want %b edge %0d", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, e);
         end
         if (e == LAT) begin
            nchk++;
            if ({valid, code} !== {1'b1, 3'd1}) begin
               nfail++; $display("FAIL entry_ready: got valid/code %b/%0d want 1/1", valid, code);
            end
         end
      end
      cleanup();
   endtask

   task automatic test_reset_hold();
      I_n = 8'b1111_1011;
      repeat (LAT) @(negedge clk);
      nchk++;
      if ({valid, code} !== {1'b1, 3'd2}) begin
         nfail++; $display("FAIL rsthold_capture: got valid/code %b/%0d want 1/2", valid, code);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nchk++;
      if ({code, valid, GS_n, EO_n} !== 6'b000011) begin
         nfail++; $display("FAIL rsthold_reset: got %b want 000011", {code, valid, GS_n, EO_n});
      end
      cleanup();
   endtask

   task automatic test_random();
      automatic int hold = 0;
      for (int c = 0; c < 800; c++) begin
         if (hold == 0) begin
            case ($urandom_range(0, 3))
               0: I_n = 8'hFF;
               1, 2: I_n = ~(8'h01 << $urandom_range(0, 7));
               default: I_n = 8'($urandom);
            endcase
            hold = $urandom_range(1, 10);
         end
         hold--;
         EI_n  = ($urandom_range(0, 15) == 0);
         ready = $urandom_range(0, 1) == 1;
         rst_n = ($urandom_range(0, 149) != 0);
         @(negedge clk); nchk++;
         if ({code, valid, GS_n, EO_n} !== {mcode, mvalid, mgs, meo}) begin
            nfail++; $display("FAIL random_model: got %b want %b cyc %0d", {code, valid, GS_n, EO_n}, {mcode, mvalid, mgs, meo}, c);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_single_report();
      test_bounce();
      test_enable();
      test_expiry_change();
      test_reset_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/prio_encoder_8to3_sync.md
# prio_encoder_8to3_sync

Registered, debounced 8-to-3 priority encoder with a valid/ready output handshake. It is the encoding counterpart of the 74LS138-style 3-to-8 decoder. It accepts eight active-low request lines (bit 7 highest priority) plus an active-low enable, in the style of the 74LS148. Each stable request is reported exactly once as a 3-bit binary code. Intended for key/switch inputs feeding downstream logic that consumes one code per press.

## Interface

Parameters:
- `STABLE_CYCLES`, default 4: consecutive cycles the encoded index must hold before capture; legal range 1..255.
- `CNT_W`, default 8: width of the stability counter; must hold `STABLE_CYCLES-1`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous reset, active-low.
- `EI_n`  in  1: enable, active-low, used unsynchronized (quasi-static).
- `I_n`  in  8: request lines, active-low, asynchronous to `clk`; bit 7 has highest priority.
- `code`  out  3: index of the highest-priority captured request, true binary.
- `valid`  out  1: `code` holds an unconsumed capture.
- `ready`  in  1: consumer accepts `code` when `valid & ready` at a rising edge.
- `GS_n`  out  1: registered group-select; low when enabled and any synchronized request is low.
- `EO_n`  out  1: registered enable-out; low when enabled and no synchronized request.

## Operation

- **Synchronizer:** two-flop synchronizer `s1`→`s2` on `I_n`, both reset to 8'hFF.
- **Priority encode:** combinational on `s2`.
  - `any` = at least one `s2` bit is 0.
  - `idx` = highest bit position that is 0; `idx` = 0 when `any` = 0.
- **Flags:** registered every cycle.
  - `GS_n` <= ~(~`EI_n` & `any`).
  - `EO_n` <= ~(~`EI_n` & ~`any`).
- **IDLE:** `valid` = 0.
  - If `EI_n`=0 and `any`: go to SETTLE, set `cand` <= `idx`, `cnt` <= 0.
- **SETTLE:**
  - If `EI_n`=1 or !`any`: go to IDLE.
  - Else if `idx` != `cand`: `cand` <= `idx`, `cnt` <= 0.
  - Else if `cnt` == `STABLE_CYCLES-1`: go to HOLD, `code` <= `cand`, `valid` <= 1.
  - Else `cnt` <= `cnt`+1.
- **HOLD:** `valid` = 1, `code` frozen.
  - Changes to `I_n`/`EI_n` are ignored; a capture is never dropped.
  - On `ready`=1: `valid` <= 0, go to RELEASE.
- **RELEASE:** on `EI_n`=1 or !`any`, go to IDLE. A held press is reported exactly once.
- `ready` outside HOLD is ignored.
- `code` retains its last captured value after acceptance.

## Timing

- **Reset:** `rst_n`=0 at any edge, including mid-SETTLE or HOLD, forces:
  - state IDLE, `s1`=`s2`=8'hFF, `cnt`=0, `cand`=0;
  - `code`=3'b000, `valid`=0, `GS_n`=1, `EO_n`=1.
- **Capture latency**, counting the first rising edge after `I_n` changes as edge 1:
  - `s2` is valid after edge 2; IDLE→SETTLE at edge 3.
  - `valid` rises at edge `STABLE_CYCLES`+3 (edge 7 at default).
- **Flags:** `GS_n`/`EO_n` settle one edge after `s2`, i.e. at edge 3.
- **Handshake:** `valid` falls on the edge where `valid & ready`=1. The earliest next capture needs RELEASE→IDLE, then a full settle.
- **Simultaneous events:**
  - A change of the highest request in the same cycle the counter would expire restarts the count; no capture occurs.
  - `ready` asserted in the same edge as entry to HOLD has no effect. `valid` must be seen high first, which gives a minimum of 1 cycle of `valid`.

## Configuration

- Macro: `PRIO_ENC_DEBOUNCE_EN`.
- **Defined:** SETTLE state and stability counter as specified.
- **Undefined:**
  - SETTLE, `cnt` and `cand` are not built; `STABLE_CYCLES` is ignored.
  - IDLE with `EI_n`=0 and `any` goes directly to HOLD with `code` <= `idx`, `valid` <= 1.
  - `valid` rises at edge 3.
  - All other behaviour is unchanged.

## Test plan

- **Reset values:** hold `rst_n`=0 for 2 cycles with `I_n`=8'h00 → `code`=0, `valid`=0, `GS_n`=1, `EO_n`=1. Release with `I_n`=8'hFF, `EI_n`=0 → `EO_n`=0 after 1 edge, `valid` stays 0.
- **Priority and latency:** `EI_n`=0, `I_n`=8'b1101_0111, `ready`=0 → `GS_n`=0 at edge 3. `valid`=1, `code`=3'd5 at edge 7 and held. Pulse `ready` → `valid`=0 next edge.
- **Single report per press:** after acceptance keep `I_n`=8'b1101_0111 for 20 cycles → `valid` stays 0. Set `I_n`=8'hFF, then 8'b1111_1110 → `code`=3'd0, `valid`=1.
- **Bounce rejection:** drive `I_n` alternating between bit 3 and bit 6 low every 2 cycles for 20 cycles → `valid` never rises. Settle on bit 6 → `code`=3'd6 after `STABLE_CYCLES`+3 edges.
- **Enable gating:** `EI_n`=1, `I_n`=8'h00 → `valid`=0, `GS_n`=1, `EO_n`=1. Drop `EI_n` → capture `code`=3'd7.
- **Reset mid-HOLD, macro undefined:** bit 2 pressed → `valid`=1 at edge 3. Assert `rst_n`=0 for one edge → `valid`=0, `code`=0.
